// File: rtl/data_mem_responder_pkg.sv
// Shared types and lane helpers for the data-port memory responder.
// Size encodings, FSM states and store byte-lane placement.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_t;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = 4'b0011 << addr_lo;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Moves right-justified store data onto the lanes selected by byte_en.
    function automatic logic [31:0] lane_shift(input logic [1:0] size, input logic [1:0] addr_lo,
                                               input logic [31:0] wdata);
        logic [31:0] lanes;
        case (size)
            SZ_BYTE: lanes = 32'(wdata[7:0]) << {addr_lo, 3'b000};
            SZ_HALF: lanes = 32'(wdata[15:0]) << {addr_lo[1], 4'b0000};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the core's data port and the responder.
interface data_mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [7:0]  err_cnt;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, err_cnt
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, err_cnt
    );

endinterface

// File: rtl/byte_lane_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module byte_lane_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // The read register only updates on a load, so it holds the last loaded word.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// One-at-a-time load/store responder: latches a request, waits, accesses the
// byte-lane RAM and returns a single-cycle response with data or an error flag.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    data_mem_responder_if.slave  bus
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic        rdata_ok_q;
    logic [7:0]  err_cnt_q;

    logic        we_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic [31:0] wdata_q;

    logic        err;
    logic [31:0] word_idx;
    logic        ram_en;
    logic [31:0] ram_rdata;

    always_ff @(posedge clk) begin
        if (bus.req_valid && ready_q) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            size_q  <= bus.req_size;
            wdata_q <= bus.req_wdata;
        end
    end

    always_comb begin
        word_idx = {2'b00, addr_q[31:2]};
        err      = 1'b0;
        case (size_q)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = addr_q[0];
            SZ_WORD: err = |addr_q[1:0];
            default: err = 1'b1;
        endcase
        if (word_idx >= 32'(DEPTH_WORDS)) begin
            err = 1'b1;
        end
    end

    assign ram_en = (state == ACCESS) && !err;

    byte_lane_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (we_q),
        .be    (byte_en(size_q, addr_q[1:0])),
        .idx   (addr_q[AW+1:2]),
        .wdata (lane_shift(size_q, addr_q[1:0], wdata_q)),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_ok_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && ready_q) begin
                        ready_q  <= 1'b0;
                        wait_cnt <= '0;
                        state    <= (WAIT_STATES > 0) ? WAIT : ACCESS;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'(WAIT_STATES - 1)) begin
                        state <= ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                ACCESS: begin
                    state       <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= err;
                    rdata_ok_q  <= !err && !we_q;
                    if (err && (err_cnt_q != 8'hFF)) begin
                        err_cnt_q <= err_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    rsp_valid_q <= 1'b0;
                    ready_q     <= 1'b1;
                end
            endcase
        end
    end

    // The RAM read register is only trusted after a successful load.
    assign bus.rsp_rdata = rdata_ok_q ? ram_rdata : 32'h0;
    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (one and zero wait states)
// checked against a byte-addressed reference memory.
module tb_data_mem_responder;

    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_responder_if if1 ();
    data_mem_responder_if if0 ();

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(if1)
    );
    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(if0)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0]  mb [2][DEPTH*4];
    bit          kb [2][DEPTH*4];
    int          ecnt [2];
    logic [31:0] last_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ready(input int s);
        return s != 0 ? if1.req_ready : if0.req_ready;
    endfunction
    function automatic logic get_rv(input int s);
        return s != 0 ? if1.rsp_valid : if0.rsp_valid;
    endfunction
    function automatic logic get_err(input int s);
        return s != 0 ? if1.rsp_err : if0.rsp_err;
    endfunction
    function automatic logic [31:0] get_rdata(input int s);
        return s != 0 ? if1.rsp_rdata : if0.rsp_rdata;
    endfunction
    function automatic logic [7:0] get_cnt(input int s);
        return s != 0 ? if1.err_cnt : if0.err_cnt;
    endfunction

    task automatic drive(input int s, input logic v, input logic we, input logic [31:0] a,
                         input logic [1:0] sz, input logic [31:0] wd);
        if (s != 0) begin
            if1.req_valid = v; if1.req_we = we; if1.req_addr = a; if1.req_size = sz; if1.req_wdata = wd;
        end else begin
            if0.req_valid = v; if0.req_we = we; if0.req_addr = a; if0.req_size = sz; if0.req_wdata = wd;
        end
    endtask

    // Reference: byte-addressed memory, errors from size/alignment/range rules.
    task automatic model_op(input int s, input logic we, input logic [31:0] a, input logic [1:0] sz,
                            input logic [31:0] wd, output logic e, output logic [31:0] rd,
                            output bit known);
        int unsigned nb;
        int unsigned base;
        nb = 1 << sz;
        e = (sz == 2'b11) || ((a % nb) != 0) || ((a / 4) >= DEPTH);
        rd = 32'h0;
        known = 1'b1;
        if (e) begin
            if (ecnt[s] < 255) ecnt[s]++;
        end else if (we) begin
            for (int i = 0; i < int'(nb); i++) begin
                mb[s][a + i] = wd[8*i +: 8];
                kb[s][a + i] = 1'b1;
            end
        end else begin
            base = a & ~32'd3;
            for (int i = 0; i < 4; i++) begin
                rd[8*i +: 8] = mb[s][base + i];
                known = known && kb[s][base + i];
            end
        end
    endtask

    task automatic req(input int s, input logic we, input logic [31:0] a, input logic [1:0] sz,
                       input logic [31:0] wd);
        logic e;
        logic [31:0] rd;
        bit known;
        int lat;
        int n;
        model_op(s, we, a, sz, wd, e, rd, known);
        @(negedge clk);
        drive(s, 1'b1, we, a, sz, wd);
        n = 0;
        while (!get_ready(s) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_accept", 32'(get_ready(s)), 32'd1);
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs after accept; the latched request must be used.
        drive(s, 1'b0, 1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)), $urandom);
        check("ready_busy", 32'(get_ready(s)), 32'd0);
        lat = 0;
        while (!get_rv(s) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("rsp_latency", 32'(lat), (s != 0) ? 32'd2 : 32'd1);
        check("rsp_err", 32'(get_err(s)), 32'(e));
        if (known) check("rsp_rdata", get_rdata(s), rd);
        check("err_cnt", 32'(get_cnt(s)), 32'(ecnt[s]));
        last_rdata = get_rdata(s);
        @(negedge clk);
        check("rsp_one_cycle", 32'(get_rv(s)), 32'd0);
        check("ready_after_rsp", 32'(get_ready(s)), 32'd1);
        check("rsp_hold", get_rdata(s), last_rdata);
    endtask

    // req_valid held high with a new address every cycle.
    task automatic held_valid(input int s, input int ncyc);
        logic [31:0] q [$];
        logic [31:0] a;
        logic [31:0] exp;
        logic e;
        bit known;
        int prev;
        int served;
        int per;
        prev = -1;
        served = 0;
        per = (s != 0) ? 4 : 3;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (get_rv(s)) begin
                check("hv_pending", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    exp = q.pop_front();
                    check("hv_rdata", get_rdata(s), exp);
                    check("hv_err", 32'(get_err(s)), 32'd0);
                    served++;
                end
            end
            a = 32'h100 + 32'(4 * (c % 16));
            if (get_ready(s)) begin
                if (prev >= 0) check("hv_period", 32'(c - prev), 32'(per));
                prev = c;
                model_op(s, 1'b0, a, 2'b10, 32'h0, e, exp, known);
                q.push_back(exp);
            end
            drive(s, 1'b1, 1'b0, a, 2'b10, 32'h0);
        end
        for (int d = 0; d < 12; d++) begin
            @(negedge clk);
            if (d == 0) drive(s, 1'b0, 1'b0, 32'h0, 2'b10, 32'h0);
            if (get_rv(s) && q.size() != 0) begin
                exp = q.pop_front();
                check("hv_rdata", get_rdata(s), exp);
                served++;
            end
        end
        check("hv_drained", 32'(q.size()), 32'd0);
        check("hv_served_enough", 32'(served >= ncyc / per - 1), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        ecnt[0] = 0;
        ecnt[1] = 0;
        drive(1, 1'b0, 1'b0, 32'h0, 2'b10, 32'h0);
        drive(0, 1'b0, 1'b0, 32'h0, 2'b10, 32'h0);
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("rst_ready", 32'(get_ready(s)), 32'd1);
            check("rst_rsp_valid", 32'(get_rv(s)), 32'd0);
            check("rst_rdata", get_rdata(s), 32'h0);
            check("rst_err", 32'(get_err(s)), 32'd0);
            check("rst_err_cnt", 32'(get_cnt(s)), 32'd0);
        end
        reset_n = 1'b1;

        // Basic store/load and byte/half merging.
        req(1, 1'b1, 32'h10, 2'b10, 32'hDEADBEEF);
        req(1, 1'b0, 32'h10, 2'b10, 32'h0);
        check("tp_word_load", last_rdata, 32'hDEADBEEF);
        req(1, 1'b1, 32'h20, 2'b10, 32'h11223344);
        req(1, 1'b1, 32'h22, 2'b00, 32'h000000AA);
        req(1, 1'b0, 32'h20, 2'b10, 32'h0);
        check("tp_byte_merge", last_rdata, 32'h11AA3344);
        req(1, 1'b1, 32'h20, 2'b01, 32'h00005566);
        req(1, 1'b0, 32'h20, 2'b10, 32'h0);
        check("tp_half_merge", last_rdata, 32'h11AA5566);

        // Reset in WAIT during a store: no response, store discarded.
        req(1, 1'b1, 32'h40, 2'b10, 32'h01234567);
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 32'h40, 2'b10, 32'hCAFEF00D);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 32'h0, 2'b10, 32'h0);
        reset_n = 1'b0;
        ecnt[0] = 0;
        ecnt[1] = 0;
        #1;
        check("arst_ready", 32'(get_ready(1)), 32'd1);
        check("arst_rsp_valid", 32'(get_rv(1)), 32'd0);
        check("arst_rdata", get_rdata(1), 32'h0);
        check("arst_err", 32'(get_err(1)), 32'd0);
        check("arst_err_cnt", 32'(get_cnt(1)), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("arst_no_rsp", 32'(get_rv(1)), 32'd0);
        end
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_no_rsp", 32'(get_rv(1)), 32'd0);
        end
        req(1, 1'b0, 32'h40, 2'b10, 32'h0);
        check("arst_store_dropped", last_rdata, 32'h01234567);

        // Error cases leave memory untouched.
        req(1, 1'b1, 32'h0, 2'b10, 32'h13579BDF);
        req(1, 1'b0, 32'h21, 2'b01, 32'h0);
        req(1, 1'b0, 32'h22, 2'b10, 32'h0);
        req(1, 1'b1, 32'h1000, 2'b10, 32'hFFFFFFFF);
        req(1, 1'b0, 32'h20, 2'b11, 32'h0);
        check("tp_err_cnt4", 32'(get_cnt(1)), 32'd4);
        req(1, 1'b0, 32'h20, 2'b10, 32'h0);
        check("tp_err_nochange20", last_rdata, 32'h11AA5566);
        req(1, 1'b0, 32'h0, 2'b10, 32'h0);
        check("tp_err_nochange0", last_rdata, 32'h13579BDF);

        // Back-to-back throughput with req_valid held high.
        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 16; w++) req(s, 1'b1, 32'h100 + 32'(4 * w), 2'b10, 32'hA5000000 | 32'(w));
            held_valid(s, 40);
        end

        // Randomized mix of loads/stores/errors.
        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 16; w++) req(s, 1'b1, 32'(4 * w), 2'b10, $urandom);
            for (int i = 0; i < 60; i++) begin
                sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                a = 32'($urandom_range(0, 63));
                if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~(32'(1 << sz) - 32'd1);
                if ($urandom_range(0, 9) == 0) a = 32'd4096 + 32'($urandom_range(0, 255));
                req(s, 1'($urandom_range(0, 1)), a, sz, $urandom);
            end
        end

        // Saturation of the error counter.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 300; i++) req(s, 1'b0, (32'($urandom_range(0, 1000)) << 2) | 32'd1, 2'b10, 32'h0);
            check("err_cnt_saturated", 32'(get_cnt(s)), 32'd255);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
